// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MIPS memory-access stage.
//   DATA_W / REG_ADR_W : datapath and register-address widths
//   SYSCALL_HALT       : $v0 value that turns a syscall into a machine halt
//   HALF_LO / HALF_HI  : values of address bit 1 selecting a halfword
//   halt_state_e       : RUN / HALTED states of the halt controller
package mem_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_ADR_W = 5;
  localparam int HALF_W    = 16;

  localparam logic [DATA_W-1:0] SYSCALL_HALT = 32'd10;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

  function automatic logic signed [DATA_W-1:0] sext_half(input logic signed [HALF_W-1:0] h);
    return DATA_W'(h);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data RAM: 2**ADDR_WIDTH words of 32 bits, asynchronous read and
// synchronous write with independent enables for each 16-bit half.
//   CLK     : write clock
//   i_we    : {hi, lo} halfword write enables
//   i_addr  : word index
//   i_wdata : write data (each half lands in the matching half of the word)
//   o_rdata : combinational read of the addressed word
module dmem_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic [1:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  // Power-up contents are zero; reset never touches the array.
  logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (i_we[0]) r_mem[i_addr][HALF_W-1:0]      <= i_wdata[HALF_W-1:0];
    if (i_we[1]) r_mem[i_addr][DATA_W-1:HALF_W] <= i_wdata[DATA_W-1:HALF_W];
  end

  // Asynchronous read: a load in the same cycle as a store sees old data.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Performs word/halfword loads and
// stores against the internal data RAM, resolves syscalls (halt or LED
// display), keeps cycle/instruction counters and registers the MEM/WB bundle.
//   Inputs : CLK, CLR (sync, active-high), EX/MEM bundle (AluResult, R1, R2,
//            PC, PC_plus_four, Instr, WAdr, JAL, MemToReg, MemWrite,
//            RegWrite, HalfW, Syscall, Eff)
//   Outputs: Fwd_Data (combinational result for forwarding to EX),
//            MEM/WB bundle (WData_Out, WAdr_Out, RegWrite_Out, Eff_Out,
//            PC_Out, Instr_out), Halt, LedData, CycleCnt, InstrCnt
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH   = 10,
  parameter logic [DATA_W-1:0] SYSCALL_HALT = mem_stage_pkg::SYSCALL_HALT
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [DATA_W-1:0]    AluResult,
  input  logic [DATA_W-1:0]    R1,
  input  logic [DATA_W-1:0]    R2,
  input  logic [DATA_W-1:0]    PC,
  input  logic [DATA_W-1:0]    PC_plus_four,
  input  logic [DATA_W-1:0]    Instr,
  input  logic [REG_ADR_W-1:0] WAdr,
  input  logic                 JAL,
  input  logic                 MemToReg,
  input  logic                 MemWrite,
  input  logic                 RegWrite,
  input  logic                 HalfW,
  input  logic                 Syscall,
  input  logic                 Eff,
  output logic [DATA_W-1:0]    Fwd_Data,
  output logic [DATA_W-1:0]    WData_Out,
  output logic [REG_ADR_W-1:0] WAdr_Out,
  output logic                 RegWrite_Out,
  output logic                 Eff_Out,
  output logic [DATA_W-1:0]    PC_Out,
  output logic [DATA_W-1:0]    Instr_out,
  output logic                 Halt,
  output logic [DATA_W-1:0]    LedData,
  output logic [DATA_W-1:0]    CycleCnt,
  output logic [DATA_W-1:0]    InstrCnt
);

  halt_state_e r_state;
  halt_state_e w_state_nxt;

  logic                  w_v;
  logic                  w_halt_call;
  logic                  w_led_call;
  logic                  w_store;
  logic [1:0]            w_we;
  logic [DATA_W-1:0]     w_wdata;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_half_sel;
  logic [DATA_W-1:0]     w_rdata;
  logic [HALF_W-1:0]     w_rhalf;
  logic [DATA_W-1:0]     w_load;
  logic                  w_unused;

  logic [DATA_W-1:0]     r_wdata;
  logic [REG_ADR_W-1:0]  r_wadr;
  logic                  r_regwrite;
  logic                  r_eff;
  logic [DATA_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_instr;
  logic [DATA_W-1:0]     r_led;
  logic [DATA_W-1:0]     r_cycle_cnt;
  logic [DATA_W-1:0]     r_instr_cnt;

  // Upper address bits alias and byte bit 0 is meaningless for word/half access.
  assign w_unused   = ^{AluResult[DATA_W-1:ADDR_WIDTH+2], AluResult[0]};

  assign w_word_idx = AluResult[ADDR_WIDTH+1:2];
  assign w_half_sel = AluResult[1];

  assign Halt        = (r_state == ST_HALTED);
  assign w_v         = Eff & ~Halt;
  assign w_halt_call = w_v & Syscall & (R1 == SYSCALL_HALT);
  assign w_led_call  = w_v & Syscall & (R1 != SYSCALL_HALT);

  // CLR must also suppress the store that would land on the same edge.
  assign w_store = w_v & MemWrite & ~CLR;

  always_comb begin
    w_we = 2'b00;
    if (w_store) begin
      if (!HalfW)                  w_we = 2'b11;
      else if (w_half_sel == HALF_HI) w_we = 2'b10;
      else                         w_we = 2'b01;
    end
  end

  // Replicate the low half so a halfword store lands in either half.
  assign w_wdata = HalfW ? {R2[HALF_W-1:0], R2[HALF_W-1:0]} : R2;

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dmem (
    .CLK     (CLK),
    .i_we    (w_we),
    .i_addr  (w_word_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_rhalf = (w_half_sel == HALF_HI) ? w_rdata[DATA_W-1:HALF_W] : w_rdata[HALF_W-1:0];
  assign w_load  = HalfW ? sext_half(w_rhalf) : w_rdata;

  assign Fwd_Data = JAL ? PC_plus_four : (MemToReg ? w_load : AluResult);

  // Halt controller: HALTED is left only through CLR.
  always_ff @(posedge CLK) begin
    if (CLR) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_halt_call) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // MEM/WB boundary
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_wdata     <= '0;
      r_wadr      <= '0;
      r_regwrite  <= 1'b0;
      r_eff       <= 1'b0;
      r_pc        <= '0;
      r_instr     <= '0;
      r_led       <= '0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_wdata    <= Fwd_Data;
      r_wadr     <= WAdr;
      r_pc       <= PC;
      r_instr    <= Instr;
      r_regwrite <= RegWrite & w_v;
      r_eff      <= w_v;
      if (w_led_call) r_led <= R2;
      // Counts the edge that enters HALTED as well, since r_state is still RUN.
      if (r_state == ST_RUN) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_v)               r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign WData_Out    = r_wdata;
  assign WAdr_Out     = r_wadr;
  assign RegWrite_Out = r_regwrite;
  assign Eff_Out      = r_eff;
  assign PC_Out       = r_pc;
  assign Instr_out    = r_instr;
  assign LedData      = r_led;
  assign CycleCnt     = r_cycle_cnt;
  assign InstrCnt     = r_instr_cnt;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline-register outputs.
- Performs data-memory word and halfword loads and stores, and resolves syscalls (halt, or LED display).
- Keeps cycle and effective-instruction performance counters.
- Registers the write-back bundle as the MEM/WB register, and drives a combinational forwarding value back to EX.

Parameters:
- ADDR_WIDTH, 10, word-address width of the internal data RAM (1024 x 32).
- SYSCALL_HALT, 32'd10, R1 ($v0) value that makes a syscall halt the machine.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, synchronous, active-high.
- AluResult  in  32  effective address, or ALU value for write-back.
- R1  in  32  $v0 value used by syscall.
- R2  in  32  store data, and $a0 value for syscall display.
- PC  in  32  PC of the instruction in MEM.
- PC_plus_four  in  32  link value for JAL.
- Instr  in  32  instruction word in MEM.
- WAdr  in  5  destination register.
- JAL, MemToReg, MemWrite, RegWrite, HalfW, Syscall  in  1 each  control bits from EX/MEM.
- Eff  in  1  slot holds a valid (non-bubble) instruction.
- Fwd_Data  out  32  combinational MEM-stage result for forwarding.
- WData_Out  out  32  registered write-back data.
- WAdr_Out  out  5  registered destination register.
- RegWrite_Out  out  1  registered write enable.
- Eff_Out  out  1  registered valid bit.
- PC_Out, Instr_out  out  32 each  registered, for debug and trace.
- Halt  out  1  sticky halt flag; upstream gates the PC with it.
- LedData  out  32  last value displayed by syscall.
- CycleCnt  out  32  non-halted cycle count.
- InstrCnt  out  32  retired effective-instruction count.

Behaviour:
- Reset: CLR=1 at an edge clears every registered output to 0, including Halt, LedData and both counters.
  - RAM contents are not affected by CLR. They are zero-initialised at time zero only.
- Qualifier: v = Eff & !Halt. Every side effect below requires v.
- Addressing:
  - Word index = AluResult[ADDR_WIDTH+1:2]; higher address bits are ignored and alias (wrap).
  - Half select = AluResult[1]; AluResult[0] is ignored.
- Load data: HalfW=0 gives the full word. HalfW=1 gives the selected 16-bit half, sign-extended to 32 bits.
- Store:
  - Written on the edge where v & MemWrite.
  - HalfW=0 writes the whole word with R2.
  - HalfW=1 writes only the selected half with R2[15:0]; the other half is unchanged.
- Result mux (combinational, drives Fwd_Data): JAL ? PC_plus_four : MemToReg ? load data : AluResult.
- Read-after-write to the same address:
  - The load sees old contents in the cycle of the store (asynchronous read).
  - A load in the next cycle sees the new data.
- MEM/WB register (latency 1 cycle):
  - WData_Out <= result; WAdr_Out, PC_Out and Instr_out capture their inputs.
  - RegWrite_Out <= RegWrite & v; Eff_Out <= v.
  - While Halt=1, RegWrite_Out and Eff_Out stay 0.
- Syscall, on an edge with v & Syscall:
  - If R1 == SYSCALL_HALT, then Halt <= 1.
  - Otherwise LedData <= R2.
  - Only one syscall takes effect per cycle.
- Halt state machine:
  - States are RUN (Halt=0) and HALTED (Halt=1).
  - RUN goes to HALTED on a halt syscall.
  - HALTED leaves only on CLR.
  - In HALTED: no stores, no LED update, counters frozen.
- Counters:
  - CycleCnt increments on every edge in RUN, including the edge that enters HALTED.
  - InstrCnt increments on every edge with v, including the halting syscall itself.
  - Both wrap modulo 2^32.
- Simultaneous CLR with any event: CLR wins. All registers clear and no store is performed.

Decomposition:
- Package mem_stage_pkg holds:
  - SYSCALL_HALT;
  - data and register-address width constants (32, 5);
  - a half-select localparam for the lower/upper half.
- One sub-module: dmem_ram.
  - Single-port RAM with asynchronous read and synchronous write.
  - 2-bit half-word write enable {hi, lo}.
  - Parameter ADDR_WIDTH.

Test Plan:
1. Word store/load, CLR pulse first: store AluResult=0x10, R2=0xDEADBEEF (MemWrite=1, Eff=1); next cycle load 0x10 with MemToReg=1, RegWrite=1, WAdr=8 -> WData_Out=0xDEADBEEF, WAdr_Out=8, RegWrite_Out=1 one cycle later.
2. Halfword: store half R2=0x00008001 at 0x12 over word 0x11112222 -> word becomes 0x80012222; halfword load at 0x12 -> 0xFFFF8001; halfword load at 0x10 -> 0x00002222.
3. Bubble: Eff=0 with MemWrite=1, RegWrite=1 -> RAM unchanged, RegWrite_Out=0, Eff_Out=0, InstrCnt unchanged, CycleCnt +1.
4. Syscall: Syscall=1, R1=1, R2=0x55 -> LedData=0x55. Then R1=10 -> Halt=1 next cycle. Then a store and RegWrite -> no RAM change, RegWrite_Out=0, both counters frozen at their final values.
5. JAL and forwarding: JAL=1, PC_plus_four=0x3004, AluResult=0x99 -> Fwd_Data=0x3004 in the same cycle, WData_Out=0x3004 next cycle.
6. CLR while HALTED, coinciding with a store -> all outputs 0, Halt=0, store not performed, counters restart from 0.
